hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 121 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard for an in-order pipeline: tracks the destinations of
// in-flight instructions, flags decode stalls and selects forwarding sources.
module hazard_scoreboard #(
  parameter int REG_AW = 4,
  parameter int DEPTH  = 2,
  parameter int SW     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] src_1,
  input  logic [REG_AW-1:0] src_2,
  input  logic              two_src,
  input  logic [REG_AW-1:0] dest,
  input  logic              wb_en,
  input  logic              mem_r_en,
  input  logic              forward_en,
  input  logic              freeze,
  input  logic              flush,
  output logic              hazard_detected,
  output logic [2:0]        fwd_sel_1,
  output logic [2:0]        fwd_sel_2,
  output logic [3:0]        pending,
  output logic [SW-1:0]     stall_cycles
);

  // Index 0 is tracked stage 1 (the instruction now in EXE).
  logic [DEPTH-1:0]  ent_valid;
  logic [REG_AW-1:0] ent_dest [DEPTH];
  logic              exe_is_load;

  logic [DEPTH-1:0]  match_1;
  logic [DEPTH-1:0]  match_2;
  logic [3:0]        first_1;
  logic [3:0]        first_2;
  logic              load_use;
  logic              unencodable;
  logic              new_valid;

  always_comb begin
    match_1 = '0;
    match_2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match_1[k] = ent_valid[k] && (ent_dest[k] == src_1);
      match_2[k] = ent_valid[k] && two_src && (ent_dest[k] == src_2);
    end
  end

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    first_1 = '0;
    first_2 = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_1[k]) first_1 = 4'(k + 1);
      if (match_2[k]) first_2 = 4'(k + 1);
    end
  end

  // Only the EXE-stage load flag matters: older loads already have their data.
  assign load_use = exe_is_load && (match_1[0] || match_2[0]);

  // A 3-bit select cannot name stage 8, so such a match stalls until it retires.
  assign unencodable = (first_1 > 4'd7) || (first_2 > 4'd7);

  always_comb begin
    hazard_detected = 1'b0;
    fwd_sel_1       = 3'd0;
    fwd_sel_2       = 3'd0;
    if (issue_valid) begin
      if (forward_en) begin
        hazard_detected = load_use || unencodable;
        fwd_sel_1       = first_1[2:0];
        fwd_sel_2       = first_2[2:0];
      end else begin
        hazard_detected = (|match_1) || (|match_2);
      end
    end
  end

  assign new_valid = issue_valid && wb_en && !hazard_detected;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= '0;
    end else if (flush) begin
      ent_valid <= '0;
    end else if (!freeze) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        ent_valid[k] <= ent_valid[k-1];
      end
      ent_valid[0] <= new_valid;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (!flush && !freeze) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        ent_dest[k] <= ent_dest[k-1];
      end
      ent_dest[0] <= dest;
      exe_is_load <= mem_r_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (hazard_detected && !freeze && !flush && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pending = pending + 4'(ent_valid[k]);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations, then
// random traffic checked every cycle against a queue-based pipeline model.
module tb_hazard_scoreboard;
  localparam int REG_AW = 4;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [REG_AW-1:0] src_1, src_2, dest;
  logic              two_src, wb_en, mem_r_en, forward_en, freeze, flush;

  logic              hazard_a, hazard_b;
  logic [2:0]        sel1_a, sel2_a, sel1_b, sel2_b;
  logic [3:0]        pending_a, pending_b;
  logic [15:0]       stall_a_out;
  logic [1:0]        stall_b_out;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SW(16)) dut_a (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .src_1(src_1), .src_2(src_2),
    .two_src(two_src), .dest(dest), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .forward_en(forward_en), .freeze(freeze), .flush(flush),
    .hazard_detected(hazard_a), .fwd_sel_1(sel1_a), .fwd_sel_2(sel2_a),
    .pending(pending_a), .stall_cycles(stall_a_out)
  );

  hazard_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SW(2)) dut_b (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .src_1(src_1), .src_2(src_2),
    .two_src(two_src), .dest(dest), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .forward_en(forward_en), .freeze(freeze), .flush(flush),
    .hazard_detected(hazard_b), .fwd_sel_1(sel1_b), .fwd_sel_2(sel2_b),
    .pending(pending_b), .stall_cycles(stall_b_out)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] d;
    logic              l;
  } ent_t;

  ent_t sb_q[$];   // sb_q[0] = youngest in-flight slot, bubbles included
  int   stall_m16;
  int   stall_m2;

  function automatic void clear_model();
    ent_t e;
    e = '0;
    sb_q.delete();
    for (int i = 0; i < DEPTH; i++) sb_q.push_back(e);
    stall_m16 = 0;
    stall_m2  = 0;
  endfunction

  function automatic void predict(output logic haz, output int s1, output int s2);
    int f1, f2;
    f1 = 0;
    f2 = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sb_q[k].v) begin
        if (f1 == 0 && sb_q[k].d == src_1) f1 = k + 1;
        if (f2 == 0 && two_src && sb_q[k].d == src_2) f2 = k + 1;
      end
    end
    haz = 1'b0;
    s1  = 0;
    s2  = 0;
    if (issue_valid) begin
      if (forward_en) begin
        haz = sb_q[0].l && (f1 == 1 || f2 == 1);
        s1  = f1;
        s2  = f2;
      end else begin
        haz = (f1 != 0) || (f2 != 0);
      end
    end
  endfunction

  function automatic int model_pending();
    int n;
    n = 0;
    foreach (sb_q[i]) if (sb_q[i].v) n++;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin : model_update
    logic haz;
    int   a, b;
    ent_t e;
    if (rst) begin
      clear_model();
    end else begin
      predict(haz, a, b);
      if (flush) begin
        foreach (sb_q[i]) sb_q[i].v = 1'b0;
      end else if (!freeze) begin
        e.v = issue_valid && wb_en && !haz;
        e.d = dest;
        e.l = mem_r_en;
        sb_q.push_front(e);
        void'(sb_q.pop_back());
      end
      if (haz && !freeze && !flush) begin
        if (stall_m16 < 65535) stall_m16++;
        if (stall_m2 < 3) stall_m2++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic haz;
    int   s1, s2, pend;
    predict(haz, s1, s2);
    pend = model_pending();
    chk("hazard_a",  hazard_a,    haz);
    chk("sel1_a",    sel1_a,      s1);
    chk("sel2_a",    sel2_a,      s2);
    chk("pending_a", pending_a,   pend);
    chk("stall_a",   stall_a_out, stall_m16);
    chk("hazard_b",  hazard_b,    haz);
    chk("sel1_b",    sel1_b,      s1);
    chk("sel2_b",    sel2_b,      s2);
    chk("pending_b", pending_b,   pend);
    chk("stall_b",   stall_b_out, stall_m2);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [REG_AW-1:0] s1, input logic [REG_AW-1:0] s2,
                       input logic ts, input logic [REG_AW-1:0] d, input logic wb,
                       input logic ld, input logic fe, input logic fr, input logic fl);
    issue_valid = iv;
    src_1       = s1;
    src_2       = s2;
    two_src     = ts;
    dest        = d;
    wb_en       = wb;
    mem_r_en    = ld;
    forward_en  = fe;
    freeze      = fr;
    flush       = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int exp_sat[6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    clear_model();
    rst = 1'b1;
    drive(1, 3, 3, 1, 3, 1, 1, 1, 0, 0);
    @(negedge clk);
    chk("rst_hazard",  hazard_a,    0);
    chk("rst_sel1",    sel1_a,      0);
    chk("rst_pending", pending_a,   0);
    chk("rst_stall",   stall_a_out, 0);
    tick();
    tick();
    rst = 1'b0;
    idle();

    // stall-only RAW: two bubble cycles
    drive(1, 1, 2, 0, 3, 1, 0, 0, 0, 0);
    @(negedge clk); chk("raw_first_haz", hazard_a, 0); tick();
    drive(1, 3, 2, 0, 6, 1, 0, 0, 0, 0);
    @(negedge clk); chk("raw_haz_c1", hazard_a, 1); tick();
    @(negedge clk); chk("raw_haz_c2", hazard_a, 1); tick();
    @(negedge clk); chk("raw_haz_clear", hazard_a, 0); chk("raw_stall_cnt", stall_a_out, 2); tick();
    do_reset();

    // forwarding from stage 1 then stage 2
    drive(1, 0, 0, 0, 5, 1, 0, 1, 0, 0);
    @(negedge clk); chk("fwd_first_haz", hazard_a, 0); tick();
    drive(1, 1, 5, 1, 8, 1, 0, 1, 0, 0);
    @(negedge clk); chk("fwd_haz_s1", hazard_a, 0); chk("fwd_sel2_s1", sel2_a, 1); chk("fwd_sel1_s1", sel1_a, 0); tick();
    @(negedge clk); chk("fwd_haz_s2", hazard_a, 0); chk("fwd_sel2_s2", sel2_a, 2); tick();
    do_reset();

    // load-use: one bubble then forward from stage 2
    drive(1, 0, 0, 0, 7, 1, 1, 1, 0, 0); tick();
    drive(1, 7, 0, 0, 9, 1, 0, 1, 0, 0);
    @(negedge clk); chk("lu_haz", hazard_a, 1); tick();
    @(negedge clk); chk("lu_haz_clear", hazard_a, 0); chk("lu_sel1", sel1_a, 2); tick();
    do_reset();

    // youngest-stage priority; src_2 ignored without two_src
    drive(1, 0, 0, 0, 4, 1, 0, 1, 0, 0); tick();
    tick();
    drive(1, 4, 4, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk); chk("prio_sel1", sel1_a, 1); chk("prio_sel2", sel2_a, 0); chk("prio_haz", hazard_a, 0); tick();
    do_reset();

    // freeze during a stall, then flush under freeze
    drive(1, 0, 0, 0, 3, 1, 0, 0, 0, 0); tick();
    drive(1, 3, 0, 0, 6, 1, 0, 0, 0, 0);
    @(negedge clk); chk("frz_haz", hazard_a, 1); tick();
    drive(1, 3, 0, 0, 6, 1, 0, 0, 1, 0);
    repeat (3) begin
      @(negedge clk);
      chk("frz_pending", pending_a, 1); chk("frz_stall", stall_a_out, 1); chk("frz_haz_hold", hazard_a, 1);
      tick();
    end
    drive(1, 3, 0, 0, 6, 1, 0, 0, 1, 1); tick();
    drive(1, 3, 0, 0, 6, 1, 0, 0, 0, 0);
    @(negedge clk); chk("flush_pending", pending_a, 0); chk("flush_haz", hazard_a, 0); chk("flush_stall", stall_a_out, 1); tick();
    do_reset();

    // 2-bit counter saturation over six stall edges
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 3, 1, 0, 0, 0, 0); tick();
      drive(1, 3, 0, 0, 5, 0, 0, 0, 0, 0);
      @(negedge clk); chk("sat_haz", hazard_b, 1); tick();
      @(negedge clk); chk("sat_cnt", stall_b_out, exp_sat[2*i]); tick();
      @(negedge clk); chk("sat_cnt", stall_b_out, exp_sat[2*i+1]); chk("sat_haz_clear", hazard_b, 0); tick();
    end
    chk("sat_wide_cnt", stall_a_out, 6);

    // reset pulse in the middle of a stall
    drive(1, 0, 0, 0, 3, 1, 0, 0, 0, 0); tick();
    drive(1, 3, 0, 0, 5, 1, 0, 0, 0, 0); tick();
    chk("mid_haz_before", hazard_b, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_haz", hazard_b, 0);
    chk("mid_rst_pending", pending_b, 0);
    chk("mid_rst_stall_b", stall_b_out, 0);
    chk("mid_rst_stall_a", stall_a_out, 0);
    tick();
    rst = 1'b0;
    drive(1, 0, 0, 0, 2, 1, 0, 0, 0, 0); tick();
    drive(1, 2, 0, 0, 5, 1, 0, 0, 0, 0);
    @(negedge clk); chk("post_rst_pending", pending_a, 1); chk("post_rst_haz", hazard_a, 1); tick();
    do_reset();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ((c % 64) == 0) forward_en = 1'($urandom_range(0, 1));
      drive($urandom_range(0, 7) != 0, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, forward_en, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
